// File: rtl/deal_controller_if.sv
// Deal controller bus: start/deck inputs, card-memory port, hand outputs.
// master = controller side, slave = memory/player/sequencer side.
interface deal_controller_if #(
  parameter int NUM_PLAYERS = 4
);
  logic                      start;
  logic [9:0]                deck_head;
  logic [9:0]                mem_addr;
  logic                      mem_rd;
  logic [9:0]                mem_rdata;
  logic                      mem_wr;
  logic [9:0]                mem_wdata;
  logic [NUM_PLAYERS-1:0]    hand_load;
  logic [10*NUM_PLAYERS-1:0] hand_addr;
  logic [9:0]                deck_rest;
  logic                      busy;
  logic                      done;
  logic                      error;

  modport master (
    input  start, deck_head, mem_rdata,
    output mem_addr, mem_rd, mem_wr, mem_wdata,
    output hand_load, hand_addr, deck_rest,
    output busy, done, error
  );

  modport slave (
    output start, deck_head, mem_rdata,
    input  mem_addr, mem_rd, mem_wr, mem_wdata,
    input  hand_load, hand_addr, deck_rest,
    input  busy, done, error
  );
endinterface

// File: rtl/deal_controller.sv
// Initial-deal sequencer: unlinks deck cards and prepends them onto hands.
// Ports: clk, resetn (async low), bus (deal_controller_if.master).
// DEAL_CTRL_BLOCK_EN: block dealing (HAND_SIZE cards per player in a run).
module deal_controller #(
  parameter int         NUM_PLAYERS = 4,
  parameter int         HAND_SIZE   = 5,
  parameter logic [9:0] NULL_PTR    = 10'h3FF
) (
  input logic               clk,
  input logic               resetn,
  deal_controller_if.master bus
);
  localparam int N  = NUM_PLAYERS * HAND_SIZE;
  localparam int CW = $clog2(N + 1);
  localparam int PW = $clog2(NUM_PLAYERS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_LINK,
    S_LOAD,
    S_DONE,
    S_ERR
  } state_t;

  state_t        state;
  logic [9:0]    cur;
  logic [9:0]    nxt;
  logic [9:0]    head_p;
  logic [PW-1:0] p;
  logic [PW-1:0] p_wrap;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          last;

`ifdef DEAL_CTRL_BLOCK_EN
  localparam int RW = $clog2(HAND_SIZE + 1);
  logic [RW-1:0] run;
`endif

  assign cnt_inc = cnt + CW'(1);
  assign last    = (cnt_inc == CW'(N));
  assign p_wrap  = (p == PW'(NUM_PLAYERS - 1)) ? '0 : p + 1'b1;

  // Current head of player p, old value becomes the new card's next.
  always_comb begin
    head_p = NULL_PTR;
    for (int i = 0; i < NUM_PLAYERS; i++)
      if (p == PW'(i)) head_p = bus.hand_addr[10*i +: 10];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= S_IDLE;
      cur           <= '0;
      nxt           <= '0;
      p             <= '0;
      cnt           <= '0;
`ifdef DEAL_CTRL_BLOCK_EN
      run           <= '0;
`endif
      bus.mem_addr  <= '0;
      bus.mem_rd    <= 1'b0;
      bus.mem_wr    <= 1'b0;
      bus.mem_wdata <= '0;
      bus.hand_load <= '0;
      bus.hand_addr <= {NUM_PLAYERS{NULL_PTR}};
      bus.deck_rest <= NULL_PTR;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.error     <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (bus.start) begin
            bus.done      <= 1'b0;
            bus.error     <= 1'b0;
            bus.hand_addr <= {NUM_PLAYERS{NULL_PTR}};
            bus.deck_rest <= NULL_PTR;
            cur           <= bus.deck_head;
            p             <= '0;
            cnt           <= '0;
`ifdef DEAL_CTRL_BLOCK_EN
            run           <= '0;
`endif
            if (bus.deck_head == NULL_PTR) begin
              bus.error <= 1'b1;
              state     <= S_ERR;
            end else begin
              bus.busy     <= 1'b1;
              bus.mem_rd   <= 1'b1;
              bus.mem_addr <= bus.deck_head;
              state        <= S_READ;
            end
          end
        end
        S_READ: begin
          bus.mem_rd <= 1'b0;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          nxt           <= bus.mem_rdata;
          bus.mem_wr    <= 1'b1;
          bus.mem_addr  <= cur;
          bus.mem_wdata <= head_p;
          state         <= S_LINK;
        end
        S_LINK: begin
          bus.mem_wr <= 1'b0;
          cur        <= nxt;
          cnt        <= cnt_inc;
          for (int i = 0; i < NUM_PLAYERS; i++)
            if (p == PW'(i)) bus.hand_addr[10*i +: 10] <= cur;
`ifdef DEAL_CTRL_BLOCK_EN
          if (run == RW'(HAND_SIZE - 1)) begin
            run <= '0;
            p   <= p_wrap;
          end else begin
            run <= run + 1'b1;
          end
`else
          p <= p_wrap;
`endif
          // Hand count reached wins over an exhausted deck.
          if (last) begin
            bus.deck_rest <= nxt;
            bus.hand_load <= '1;
            state         <= S_LOAD;
          end else if (nxt == NULL_PTR) begin
            bus.error <= 1'b1;
            bus.busy  <= 1'b0;
            state     <= S_ERR;
          end else begin
            bus.mem_rd   <= 1'b1;
            bus.mem_addr <= nxt;
            state        <= S_READ;
          end
        end
        S_LOAD: begin
          bus.hand_load <= '0;
          bus.done      <= 1'b1;
          bus.busy      <= 1'b0;
          state         <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_deal_controller.sv
// Bench for deal_controller: random decks against a list-level deal model.
// Ports: none (top-level testbench).
module tb_deal_controller;
  localparam int         NP   = 2;
  localparam int         HS   = 2;
  localparam int         NC   = NP * HS;
  localparam logic [9:0] NULL = 10'h3FF;

  logic clk;
  logic resetn;

  deal_controller_if #(.NUM_PLAYERS(NP)) bus();

  deal_controller #(
    .NUM_PLAYERS(NP),
    .HAND_SIZE  (HS),
    .NULL_PTR   (NULL)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [9:0]  mem [1024];
  logic [9:0]  deck_q[$];
  int          n_checks;
  int          n_fail;
  int          cyc_done;
  int          cyc_err;
  int          cyc_load;
  int          n_load;
  int          n_rd;
  int          n_wr;
  int          n_both;
  logic [NP-1:0] load_val;
  bit          timed_out;
  bit          reset_hit;

  task automatic build_deck(input int len, input bit rnd);
    bit used [1024];
    int a;
    deck_q.delete();
    for (int i = 0; i < 1024; i++) used[i] = 1'b0;
    for (int i = 0; i < len; i++) begin
      if (rnd) begin
        do a = $urandom_range(0, 1022); while (used[a]);
      end else begin
        a = i;
      end
      used[a] = 1'b1;
      deck_q.push_back(10'(a));
    end
    for (int i = 0; i < len; i++)
      mem[deck_q[i]] = (i + 1 < len) ? deck_q[i+1] : NULL;
  endtask

  // Starts a deal and acts as card memory until done/error/reset.
  task automatic run_deal(input logic [9:0] head, input int pulse_at,
                          input int reset_at);
    cyc_done = -1; cyc_err = -1; cyc_load = -1;
    n_load = 0; n_rd = 0; n_wr = 0; n_both = 0;
    load_val = '0; timed_out = 1'b1; reset_hit = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.deck_head = head;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (bus.mem_rd) n_rd++;
      if (bus.mem_wr) n_wr++;
      if (bus.mem_rd && bus.mem_wr) n_both++;
      if (bus.hand_load != '0) begin
        n_load++;
        cyc_load = n;
        load_val = bus.hand_load;
      end
      if (bus.done && cyc_done < 0) cyc_done = n;
      if (bus.error && cyc_err < 0) cyc_err = n;
      if (bus.done || bus.error) begin
        timed_out = 1'b0;
        break;
      end
      if (n == reset_at) begin
        resetn = 1'b0;
        #1;
        reset_hit = 1'b1;
        timed_out = 1'b0;
        break;
      end
      if (n == pulse_at) begin
        bus.start = 1'b1;
        bus.deck_head = 10'h155;
      end
      if (n == pulse_at + 1) bus.start = 1'b0;
      @(posedge clk);
      if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
      else bus.mem_rdata <= 10'($urandom);
      if (bus.mem_wr) mem[bus.mem_addr] = bus.mem_wdata;
    end
    bus.start = 1'b0;
  endtask

  // Deal deck_q and compare with a list-level model of the deal.
  task automatic test_deal(input string name, input int pulse_at);
    int         len;
    int         dealt;
    int         pl;
    bit         ok;
    logic [9:0] eh [NP];
    logic [9:0] enx [$];
    logic [9:0] exp_rest;
    logic [9:0] want;
    int         exp_done;
    int         exp_err;
    int         exp_load;
    len = deck_q.size();
    dealt = (len < NC) ? len : NC;
    ok = (len >= NC);
    for (int i = 0; i < NP; i++) eh[i] = NULL;
    enx.delete();
    for (int i = 0; i < dealt; i++) begin
`ifdef DEAL_CTRL_BLOCK_EN
      pl = i / HS;
`else
      pl = i % NP;
`endif
      enx.push_back(eh[pl]);
      eh[pl] = deck_q[i];
    end
    exp_rest = (len > NC) ? deck_q[NC] : NULL;
    exp_done = ok ? 2 + 3*NC : -1;
    exp_load = ok ? 1 + 3*NC : -1;
    exp_err  = ok ? -1 : 1 + 3*len;
    run_deal((len > 0) ? deck_q[0] : NULL, pulse_at, 0);

    n_checks++;
    if (timed_out !== 1'b0) begin
      n_fail++;
      $display("FAIL %s timeout: no done/error within budget", name);
    end
    n_checks++;
    if (cyc_done !== exp_done) begin
      n_fail++;
      $display("FAIL %s done_cycle: got %0d want %0d", name, cyc_done, exp_done);
    end
    n_checks++;
    if (cyc_err !== exp_err) begin
      n_fail++;
      $display("FAIL %s error_cycle: got %0d want %0d", name, cyc_err, exp_err);
    end
    n_checks++;
    if (cyc_load !== exp_load || n_load !== (ok ? 1 : 0)) begin
      n_fail++;
      $display("FAIL %s load: got cyc %0d cnt %0d want cyc %0d cnt %0d",
               name, cyc_load, n_load, exp_load, ok ? 1 : 0);
    end
    if (ok) begin
      n_checks++;
      if (load_val !== '1) begin
        n_fail++;
        $display("FAIL %s load_val: got %b want all ones", name, load_val);
      end
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy: got %b want 0", name, bus.busy);
    end
    n_checks++;
    if (bus.deck_rest !== exp_rest) begin
      n_fail++;
      $display("FAIL %s deck_rest: got %h want %h", name, bus.deck_rest, exp_rest);
    end
    for (int i = 0; i < NP; i++) begin
      n_checks++;
      if (bus.hand_addr[10*i +: 10] !== eh[i]) begin
        n_fail++;
        $display("FAIL %s head%0d: got %h want %h",
                 name, i, bus.hand_addr[10*i +: 10], eh[i]);
      end
    end
    n_checks++;
    if (n_rd !== dealt || n_wr !== dealt || n_both !== 0) begin
      n_fail++;
      $display("FAIL %s mem_ops: got rd %0d wr %0d both %0d want %0d %0d 0",
               name, n_rd, n_wr, n_both, dealt, dealt);
    end
    for (int i = 0; i < len; i++) begin
      if (i < dealt) want = enx[i];
      else want = (i + 1 < len) ? deck_q[i+1] : NULL;
      n_checks++;
      if (mem[deck_q[i]] !== want) begin
        n_fail++;
        $display("FAIL %s node %h next: got %h want %h",
                 name, deck_q[i], mem[deck_q[i]], want);
      end
    end
  endtask

  task automatic test_reset();
    logic [10*NP-1:0] all_null;
    all_null = {NP{NULL}};
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.hand_addr !== all_null || bus.deck_rest !== NULL) begin
      n_fail++;
      $display("FAIL reset_ptrs: got %h %h want %h %h",
               bus.hand_addr, bus.deck_rest, all_null, NULL);
    end
    n_checks++;
    if ({bus.mem_rd, bus.mem_wr, bus.hand_load, bus.busy, bus.done,
         bus.error} !== '0) begin
      n_fail++;
      $display("FAIL reset_flags: got rd%b wr%b ld%b b%b d%b e%b want 0",
               bus.mem_rd, bus.mem_wr, bus.hand_load, bus.busy,
               bus.done, bus.error);
    end
    n_checks++;
    if (bus.mem_addr !== 10'd0 || bus.mem_wdata !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_mem: got %h %h want 0 0", bus.mem_addr, bus.mem_wdata);
    end
  endtask

  task automatic test_round_robin();
    logic [9:0] h0;
    build_deck(5, 1'b0);
    test_deal("plan", 0);
`ifdef DEAL_CTRL_BLOCK_EN
    h0 = 10'd1;
`else
    h0 = 10'd2;
`endif
    n_checks++;
    if (bus.hand_addr[9:0] !== h0 || bus.hand_addr[19:10] !== 10'd3 ||
        bus.deck_rest !== 10'd4) begin
      n_fail++;
      $display("FAIL plan_const: got %h %h %h want %h 003 004",
               bus.hand_addr[9:0], bus.hand_addr[19:10], bus.deck_rest, h0);
    end
  endtask

  task automatic test_short_deck();
    build_deck(3, 1'b0);
    test_deal("short", 0);
  endtask

  task automatic test_null_deck();
    build_deck(0, 1'b0);
    test_deal("null", 0);
  endtask

  task automatic test_ignored_start();
    build_deck(6, 1'b1);
    test_deal("ign_start", 3);
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 16; t++) begin
      build_deck($urandom_range(0, 7), 1'b1);
      test_deal($sformatf("rand%0d", t), 0);
    end
  endtask

  task automatic test_reset_mid_deal();
    build_deck(5, 1'b1);
    run_deal(deck_q[0], 0, 8);
    n_checks++;
    if (reset_hit !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_reach: got %b want 1", reset_hit);
    end
    n_checks++;
    if (bus.hand_addr !== {NP{NULL}} || bus.deck_rest !== NULL ||
        bus.mem_addr !== 10'd0 || bus.mem_wdata !== 10'd0) begin
      n_fail++;
      $display("FAIL midrst_regs: got %h %h %h %h want all-null null 0 0",
               bus.hand_addr, bus.deck_rest, bus.mem_addr, bus.mem_wdata);
    end
    n_checks++;
    if ({bus.mem_rd, bus.mem_wr, bus.hand_load, bus.busy, bus.done,
         bus.error} !== '0) begin
      n_fail++;
      $display("FAIL midrst_flags: got rd%b wr%b ld%b b%b d%b e%b want 0",
               bus.mem_rd, bus.mem_wr, bus.hand_load, bus.busy,
               bus.done, bus.error);
    end
    @(negedge clk);
    resetn = 1'b1;
    build_deck(5, 1'b1);
    test_deal("post_reset", 0);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    resetn = 1'b0;
    bus.start = 1'b0;
    bus.deck_head = '0;
    bus.mem_rdata = '0;
    test_reset();
    test_round_robin();
    test_short_deck();
    test_null_deck();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid_deal();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/deal_controller.md
# deal_controller

Sequences the initial deal for a card game. Walks the deck's linked list in card memory, unlinks cards one at a time and prepends each onto a per-player hand list. When the deal completes, pulses every player's `load` input with the new hand head address. Sits between the shared card memory and the `player` hand registers; it is the only card-memory master during a deal.

## Interface

**Parameters**
- `NUM_PLAYERS`, default 4: number of players, range 2–4.
- `HAND_SIZE`, default 5: cards dealt to each player, range 1–13.
- `NULL_PTR`, default 10'h3FF: end-of-list marker.

**Ports**
- `clk`  in  1  system clock; all state changes on the rising edge.
- `resetn`  in  1  reset, asynchronous and active-low.
- `start`  in  1  begin a deal; sampled only in IDLE, DONE or ERR.
- `deck_head`  in  10  head address of the deck list; sampled with `start`.
- `mem_addr`  out  10  card-memory address.
- `mem_rd`  out  1  read strobe; read data is valid the next cycle.
- `mem_rdata`  in  10  next-pointer field of the node at `mem_addr`.
- `mem_wr`  out  1  write strobe for the next-pointer field.
- `mem_wdata`  out  10  next-pointer value to write.
- `hand_load`  out  NUM_PLAYERS  per-player load pulse.
- `hand_addr`  out  10*NUM_PLAYERS  hand head per player; player p occupies bits [10p+9:10p].
- `deck_rest`  out  10  head of the undealt remainder of the deck.
- `busy`  out  1  a deal is in progress.
- `done`  out  1  the last deal completed successfully.
- `error`  out  1  the deck ran out before the deal completed.

## Operation

**Reset values**
- State IDLE.
- All `hand_addr` fields = NULL_PTR; `deck_rest` = NULL_PTR.
- `mem_rd`, `mem_wr`, `hand_load`, `busy`, `done`, `error` = 0.
- `mem_addr` = 0, `mem_wdata` = 0.

**Registers**
- `cur`: node being dealt.
- `nxt`: latched next pointer of `cur`.
- `p`: current player index.
- `cnt`: cards dealt so far; width ceil(log2(NUM_PLAYERS*HAND_SIZE+1)).

**State machine**
- **IDLE / DONE / ERR, on `start`:**
  - Clear `done` and `error`; set all heads to NULL_PTR; set `cur` = `deck_head`, `p` = 0, `cnt` = 0.
  - If `deck_head` == NULL_PTR, go to ERR; otherwise set `busy` and go to READ.
- **READ:** `mem_rd` = 1, `mem_addr` = `cur`. Go to WAIT.
- **WAIT:** `nxt` <= `mem_rdata`. Go to LINK.
- **LINK:**
  - `mem_wr` = 1, `mem_addr` = `cur`, `mem_wdata` = head[p].
  - head[p] <= `cur`; `cur` <= `nxt`; `cnt` <= `cnt` + 1.
  - `p` <= `p` + 1, wrapping from NUM_PLAYERS-1 to 0.
  - If `cnt` + 1 == NUM_PLAYERS*HAND_SIZE: `deck_rest` <= `nxt`, go to LOAD.
  - Else if `nxt` == NULL_PTR: go to ERR.
  - Else go to READ.
- **LOAD:** `hand_load` = all ones for exactly one cycle. `hand_addr` is already stable from the preceding LINK. Go to DONE.
- **DONE:** `done` = 1, `busy` = 0. Hold until the next `start`.
- **ERR:** `error` = 1, `busy` = 0, `hand_load` never pulsed. Partial heads remain visible on `hand_addr`; `deck_rest` = NULL_PTR. Hold until the next `start`.

**Rules**
- Prepending means each hand list ends in NULL_PTR and its head is the last card dealt to that player.
- `start` in READ, WAIT, LINK or LOAD is ignored.
- `mem_rd` and `mem_wr` are never asserted in the same cycle.
- `resetn` low at any point aborts immediately to reset values. Card memory is left partially relinked; a fresh deal requires a rebuilt deck.

## Timing

- `start` sampled at edge k: card i (0-based) occupies READ, WAIT, LINK in cycles k+1+3i, k+2+3i, k+3+3i.
- With N = NUM_PLAYERS*HAND_SIZE, LOAD is cycle k+1+3N and `done` rises in cycle k+2+3N.
- Error detected in the LINK of card j: `error` rises in cycle k+4+3j.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration

- **`DEAL_CTRL_BLOCK_EN` defined:** block dealing. `p` advances only after HAND_SIZE consecutive cards to the same player, so player 0 gets the first HAND_SIZE cards, and so on. Cycle counts are unchanged.
- **Undefined (default):** round-robin dealing, one card per player in turn, as described above.

## Test plan

- **Round-robin deal:** NUM_PLAYERS=2, HAND_SIZE=2, deck nodes 0→1→2→3→4→NULL, `start` at edge k.
  - Required: head0=2, node2.next=0, node0.next=NULL; head1=3, node3.next=1, node1.next=NULL.
  - `deck_rest`=4; `hand_load`=2'b11 in cycle k+13; `done` in cycle k+14.
- **Block deal (`DEAL_CTRL_BLOCK_EN`), same deck:** head0=1, node1.next=0; head1=3, node3.next=2; `deck_rest`=4.
- **Short deck:** 3-node deck with NUM_PLAYERS=2, HAND_SIZE=2 → `error` in cycle k+10, `hand_load` never asserted, `busy` low, `deck_rest`=NULL_PTR.
- **Null deck and ignored start:**
  - `deck_head`=10'h3FF → `error` the cycle after `start`, zero memory accesses.
  - `start` pulsed during LINK → no effect on the sequence or cycle counts.
- **Reset mid-deal:** drop `resetn` during the WAIT of card 2 → all outputs return to reset values asynchronously. A later `start` on a rebuilt deck completes normally.
